// File: rtl/countdown_ctrl_pkg.sv
// Shared definitions for the countdown controller: FSM state codes and default timing.
package countdown_ctrl_pkg;

   localparam int TICK_DIV_DEF = 50000000;
   localparam int CNT_W_DEF    = 26;

   typedef logic [2:0] state_t;

   localparam state_t S_IDLE    = 3'd0;
   localparam state_t S_LOAD    = 3'd1;
   localparam state_t S_ARM     = 3'd2;
   localparam state_t S_RUN     = 3'd3;
   localparam state_t S_PAUSED  = 3'd4;
   localparam state_t S_TIMEOUT = 3'd5;

endpackage

// File: rtl/countdown_ctrl_tick_prescaler.sv
// Divides clk down to one tick pulse per TICK_DIV enabled cycles; holds its count while disabled.
module tick_prescaler
   import countdown_ctrl_pkg::*;
#(
   parameter int TICK_DIV = TICK_DIV_DEF,
   parameter int CNT_W    = CNT_W_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic clr,
   output logic tick
);

   localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         cnt  <= '0;
         tick <= 1'b0;
      end else if (en) begin
         if (cnt == LAST) cnt <= '0;
         else             cnt <= cnt + 1'b1;
         tick <= (cnt == LAST);
      end else begin
         tick <= 1'b0;
      end
   end

endmodule

// File: rtl/countdown_ctrl.sv
// Countdown sequencer: reloads the digit chain on a start edge, then paces borrow ticks until the chain runs out.
module countdown_ctrl
   import countdown_ctrl_pkg::*;
#(
   parameter int TICK_DIV = TICK_DIV_DEF,
   parameter int CNT_W    = CNT_W_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic start,
   input  logic pause,
   input  logic noborrow_top,
   output logic tick,
   output logic reconfig,
   output logic running,
   output logic timeout
);

   state_t state, nxt;
   logic   start_q;
   logic   start_edge;
   logic   ps_en;
   logic   ps_clr;

   // start_q resets high so a start held through reset is not seen as a new request
   assign start_edge = start & ~start_q;

   always_comb begin
      nxt = state;
      if (start_edge) begin
         nxt = S_LOAD;
      end else begin
         case (state)
            S_IDLE:    nxt = S_IDLE;
            S_LOAD:    nxt = S_ARM;
            S_ARM:     nxt = S_RUN;
            S_RUN:     if (noborrow_top) nxt = S_TIMEOUT;
                       else if (pause)   nxt = S_PAUSED;
            S_PAUSED:  if (noborrow_top) nxt = S_TIMEOUT;
                       else if (!pause)  nxt = S_RUN;
            S_TIMEOUT: nxt = S_TIMEOUT;
            default:   nxt = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= S_IDLE;
         start_q  <= 1'b1;
         reconfig <= 1'b0;
         running  <= 1'b0;
         timeout  <= 1'b0;
      end else begin
         state    <= nxt;
         start_q  <= start;
         reconfig <= (nxt == S_LOAD);
         running  <= (nxt == S_RUN);
         timeout  <= (nxt == S_TIMEOUT);
      end
   end

   // Counting only on cycles that stay in RUN suppresses a tick on the exit cycle
   assign ps_en  = (state == S_RUN) && (nxt == S_RUN);
   assign ps_clr = (state == S_LOAD);

   tick_prescaler #(
      .TICK_DIV (TICK_DIV),
      .CNT_W    (CNT_W)
   ) u_prescaler (
      .clk  (clk),
      .rst  (rst),
      .en   (ps_en),
      .clr  (ps_clr),
      .tick (tick)
   );

endmodule

// File: tb/tb_countdown_ctrl.sv
// Scoreboard bench for countdown_ctrl with a cycle-level behavioural model and a 3-digit chain model.
module tb_countdown_ctrl;

   localparam int TD = 4;

   localparam int M_IDLE  = 0;
   localparam int M_LOAD  = 1;
   localparam int M_ARM   = 2;
   localparam int M_RUN   = 3;
   localparam int M_PAUSE = 4;
   localparam int M_TO    = 5;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic start = 1'b0;
   logic pause = 1'b0;
   logic noborrow_top = 1'b0;
   logic tick, reconfig, running, timeout;

   int checks = 0;
   int errors = 0;

   logic [3:0] expq[$];

   int   m_mode;
   logic m_prev;
   int   m_since;

   always #5 clk = ~clk;

   countdown_ctrl #(
      .TICK_DIV (TD),
      .CNT_W    (3)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .pause        (pause),
      .noborrow_top (noborrow_top),
      .tick         (tick),
      .reconfig     (reconfig),
      .running      (running),
      .timeout      (timeout)
   );

   // Reference: m_since counts RUN cycles since the last tick; every TD-th one produces a tick.
   always @(posedge clk) begin
      logic e;
      logic t;
      t = 1'b0;
      if (rst) begin
         m_mode  = M_IDLE;
         m_prev  = 1'b1;
         m_since = 0;
      end else begin
         e      = start && !m_prev;
         m_prev = start;
         if (e) begin
            m_mode  = M_LOAD;
            m_since = 0;
         end else begin
            case (m_mode)
               M_LOAD: m_mode = M_ARM;
               M_ARM:  m_mode = M_RUN;
               M_RUN: begin
                  if (noborrow_top) m_mode = M_TO;
                  else if (pause)   m_mode = M_PAUSE;
                  else begin
                     m_since = m_since + 1;
                     if (m_since == TD) begin
                        m_since = 0;
                        t = 1'b1;
                     end
                  end
               end
               M_PAUSE: begin
                  if (noborrow_top) m_mode = M_TO;
                  else if (!pause)  m_mode = M_RUN;
               end
               default: ;
            endcase
         end
      end
      expq.push_back({t, m_mode == M_LOAD, m_mode == M_RUN, m_mode == M_TO});
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      int nt;
      int v;
      bit done;

      fork
         forever begin
            @(negedge clk);
            if (expq.size() > 0) begin
               logic [3:0] ex;
               logic [3:0] got;
               ex  = expq.pop_front();
               got = {tick, reconfig, running, timeout};
               checks++;
               if (got !== ex) begin
                  errors++;
                  $display("FAIL outputs t=%0t tick/reconfig/running/timeout got=%b required=%b",
                           $time, got, ex);
               end
            end
         end
      join_none

      // reset, then a plain start with several ticks
      cyc(3); rst = 1'b0; cyc(2);
      start = 1'b1; cyc(20);
      // pause mid-count, resume, then chain exhausted
      pause = 1'b1; cyc(10); pause = 1'b0; cyc(13);
      noborrow_top = 1'b1; cyc(1); noborrow_top = 1'b0; cyc(20);
      // start edge together with noborrow_top restarts instead of timing out
      start = 1'b0; cyc(2); start = 1'b1; noborrow_top = 1'b1; cyc(1);
      noborrow_top = 1'b0; cyc(10);
      // reset during RUN with start held high: no restart until a fresh edge
      rst = 1'b1; cyc(1); rst = 1'b0; cyc(6);
      start = 1'b0; cyc(1); start = 1'b1; cyc(9);
      pause = 1'b1; cyc(1); pause = 1'b0; cyc(7);

      for (int i = 0; i < 500; i++) begin
         if ($urandom_range(0, 19) == 0) start = ~start;
         pause        = ($urandom_range(0, 9) < 2);
         noborrow_top = ($urandom_range(0, 59) == 0);
         rst          = ($urandom_range(0, 149) == 0);
         cyc(1);
      end

      // full 3-digit chain: reload to 999, borrow down on each tick, report exhaustion
      rst = 1'b1; start = 1'b0; pause = 1'b0; noborrow_top = 1'b0; cyc(2);
      rst = 1'b0; v = 0; noborrow_top = 1'b1; cyc(1);
      start = 1'b1;
      nt = 0;
      done = 1'b0;
      for (int i = 0; i < 6000 && !done; i++) begin
         @(negedge clk);
         if (tick) nt++;
         if (reconfig)         v = 999;
         else if (tick && v > 0) v = v - 1;
         noborrow_top = (v == 0);
         if (timeout) done = 1'b1;
      end
      checks++;
      if (!done) begin
         errors++;
         $display("FAIL chain_timeout got timeout=%b required=1 within 6000 cycles", timeout);
      end
      checks++;
      if (nt != 999) begin
         errors++;
         $display("FAIL chain_ticks got %0d required 999", nt);
      end
      nt = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (tick) nt++;
      end
      checks++;
      if (nt != 0) begin
         errors++;
         $display("FAIL ticks_after_timeout got %0d required 0", nt);
      end

      cyc(2);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/countdown_ctrl.md
COUNTDOWN_CTRL -- requirements
Module: countdown_ctrl

Interface
REQ-001 Parameter TICK_DIV, default 50000000, clock cycles per countdown tick (>=2).
REQ-002 Parameter CNT_W, default 26, prescaler counter width; SHALL satisfy 2**CNT_W >= TICK_DIV.
REQ-003 clk  input  1  single clock; all logic on posedge clk.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 start  input  1  start/restart request; level input, rising edge is significant.
REQ-006 pause  input  1  level; high freezes the countdown.
REQ-007 noborrow_top  input  1  no-borrow status from the most-significant digit stage; high = chain exhausted.
REQ-008 tick  output  1  one-cycle decrement request into the least-significant digit's borrow-down input.
REQ-009 reconfig  output  1  one-cycle pulse reloading all digit stages to 9.
REQ-010 running  output  1  high while in RUN.
REQ-011 timeout  output  1  high while in TIMEOUT.

Function
REQ-012 All outputs SHALL be registered; no combinational input-to-output path.
REQ-013 A start edge SHALL be start==1 in the current cycle with start==0 in the previous cycle; the previous-cycle sample resets to 1, so start held high through reset produces no edge.
REQ-014 FSM states: IDLE, LOAD, ARM, RUN, PAUSED, TIMEOUT.
REQ-015 IDLE: start edge -> LOAD; otherwise stay.
REQ-016 LOAD: lasts exactly one cycle; reconfig=1 in the cycle after entering LOAD; prescaler cleared to 0; -> ARM.
REQ-017 ARM: lasts exactly one cycle (digit status settles); noborrow_top ignored; -> RUN.
REQ-018 RUN: prescaler increments each cycle; when it equals TICK_DIV-1 it wraps to 0 and tick=1 on the following cycle; first tick therefore occurs TICK_DIV cycles after RUN is entered.
REQ-019 RUN: noborrow_top==1 -> TIMEOUT; no further ticks are issued once TIMEOUT is entered.
REQ-020 RUN: pause==1 (and noborrow_top==0) -> PAUSED; prescaler holds its value and no tick is issued.
REQ-021 PAUSED: pause==0 -> RUN; prescaler resumes from the held value.
REQ-022 TIMEOUT: hold; timeout=1 until a start edge or reset.
REQ-023 Priority in any state: start edge > noborrow_top > pause; a start edge in RUN, PAUSED, TIMEOUT or ARM -> LOAD (restart).
REQ-024 tick and reconfig SHALL never be high in the same cycle.
REQ-025 tick SHALL be high for exactly one cycle per prescaler wrap and never in IDLE, LOAD, ARM, PAUSED or TIMEOUT.
REQ-026 If a tick would be issued in the same cycle the FSM leaves RUN, the tick SHALL be suppressed.

Reset
REQ-027 rst=1 at a clock edge: state=IDLE, prescaler=0, tick=0, reconfig=0, running=0, timeout=0, previous start sample=1.
REQ-028 Reset mid-countdown SHALL abort immediately with no trailing tick or reconfig pulse.

Structure
REQ-029 Shared package holds: FSM state enumeration, default TICK_DIV and CNT_W constants.
REQ-030 Sub-module tick_prescaler (enable, clear, tick-out) implements REQ-018/020/021; the FSM and edge detect stay in countdown_ctrl.
REQ-031 Target size: 120-250 lines of RTL total.

Verification (TICK_DIV=4)
REQ-032 Start edge from IDLE -> reconfig pulse 1 cycle after the edge, ARM 1 cycle, running=1, first tick 4 cycles after RUN entry, then every 4 cycles.
REQ-033 RUN, pause high for 10 cycles mid-count -> no ticks during pause; the next tick arrives after the remaining prescaler cycles, not a full 4.
REQ-034 noborrow_top raised in RUN -> timeout=1 next cycle, running=0, zero ticks for 20 further cycles.
REQ-035 Start edge and noborrow_top high in the same cycle -> LOAD (reconfig pulse), no timeout.
REQ-036 rst pulsed during RUN with start held high -> all outputs 0, IDLE; no restart until start falls and rises again.
REQ-037 Full-chain check with three digit stages: 999 ticks after start then timeout; tick/reconfig never coincide.
